// File: rtl/lomo_param_pkg.sv
// Shared definitions for the LOMO auxiliary parameter scheduler:
// slot map, reset defaults and FSM state encoding.
package lomo_param_pkg;

    localparam int NPARAM = 7;

    localparam int SLOT_CORR = 0;
    localparam int SLOT_PEL  = 1;
    localparam int SLOT_XD   = 2;
    localparam int SLOT_YD   = 3;
    localparam int SLOT_RM   = 4;
    localparam int SLOT_POS  = 5;
    localparam int SLOT_ARU  = 6;

    // Slot k lives at element [k]; both banks come out of reset with these values.
    localparam logic [NPARAM-1:0][7:0] PARAM_DEFAULT = {
        8'd161, 8'd151, 8'd141, 8'd131, 8'd121, 8'd111, 8'd101
    };

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

endpackage

// File: rtl/lomo_rr_arbiter.sv
// Round-robin arbiter: combinational winner for same-edge use, registered
// one-hot grant pulse, and a requester is never granted two cycles running.
module lomo_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            win_vld,
    output logic [IW-1:0]   win_idx
);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [NREQ-1:0] elig;
    logic [IW:0]     cand;

    always_comb begin
        elig    = en ? (req & ~gnt) : '0;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        // Scan from the pointer upward, wrapping modulo NREQ.
        for (int o = 0; o < NREQ; o++) begin
            cand = {1'b0, ptr} + (IW+1)'(o);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!win_vld && elig[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
        ptr_nxt = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt <= '0;
            ptr <= '0;
        end else begin
            gnt <= '0;
            if (win_vld) begin
                gnt[win_idx] <= 1'b1;
                ptr          <= ptr_nxt;
            end
        end
    end

endmodule

// File: rtl/lomo_param_scheduler.sv
// Arbitrated shadow/active parameter bank for the LOMO frame serializer;
// the shadow bank is copied into the active bank only at frame boundaries.
module lomo_param_scheduler
    import lomo_param_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*3-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 frame_start,
    output logic [NREQ-1:0]      gnt,
    output logic [NPARAM*DW-1:0] param_out,
    output logic [NPARAM-1:0]    pend,
    output logic                 commit,
    output logic                 err_addr,
    output logic                 ovr,
    output logic [7:0]           upd_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t state, state_nxt;

    logic [NPARAM-1:0][DW-1:0] active;
    logic [NPARAM-1:0][DW-1:0] shadow;
    logic [NREQ-1:0][2:0]      addr_v;
    logic [NREQ-1:0][DW-1:0]   data_v;
    logic                      win_vld;
    logic [IW-1:0]             win_idx;
    logic [2:0]                wr_addr;
    logic [DW-1:0]             wr_data;
    logic                      wr_ok;
    logic [NPARAM-1:0]         wr_sel;
    logic [8:0]                upd_sum;
    logic                      in_commit;

    assign addr_v    = req_addr;
    assign data_v    = req_data;
    assign param_out = active;
    assign in_commit = (state == ST_COMMIT);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (frame_start) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Grants are only issued into cycles spent in RUN, so the decision edge
    // is enabled exactly when the next state is RUN.
    lomo_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (state_nxt == ST_RUN),
        .req     (req),
        .gnt     (gnt),
        .win_vld (win_vld),
        .win_idx (win_idx)
    );

    assign wr_addr = addr_v[win_idx];
    assign wr_data = data_v[win_idx];
    assign wr_ok   = win_vld && (wr_addr < 3'(NPARAM));
    assign upd_sum = {1'b0, upd_cnt} + 9'($countones(pend));

    always_comb begin
        wr_sel = '0;
        if (wr_ok) wr_sel[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NPARAM; k++) begin
                active[k] <= DW'(PARAM_DEFAULT[k]);
                shadow[k] <= DW'(PARAM_DEFAULT[k]);
            end
            pend     <= '0;
            commit   <= 1'b0;
            err_addr <= 1'b0;
            ovr      <= 1'b0;
            upd_cnt  <= '0;
        end else begin
            commit   <= in_commit;
            err_addr <= win_vld && !wr_ok;
            if (in_commit && frame_start) ovr <= 1'b1;
            // A write landing on the commit edge stays pending for the next frame.
            for (int k = 0; k < NPARAM; k++) begin
                if (wr_sel[k])            shadow[k] <= wr_data;
                if (in_commit && pend[k]) active[k] <= shadow[k];
            end
            pend <= (in_commit ? '0 : pend) | wr_sel;
            if (in_commit) upd_cnt <= upd_sum[8] ? 8'hFF : upd_sum[7:0];
        end
    end

endmodule

// File: tb/tb_lomo_param_scheduler.sv
// Directed self-checking bench for lomo_param_scheduler (NREQ=4, DW=8).
module tb_lomo_param_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        frame_start;
    logic [3:0]  gnt;
    logic [55:0] param_out;
    logic [6:0]  pend;
    logic        commit;
    logic        err_addr;
    logic        ovr;
    logic [7:0]  upd_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [55:0] DEF = {8'd161, 8'd151, 8'd141, 8'd131, 8'd121, 8'd111, 8'd101};

    lomo_param_scheduler #(.NREQ(4), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .frame_start (frame_start),
        .gnt         (gnt),
        .param_out   (param_out),
        .pend        (pend),
        .commit      (commit),
        .err_addr    (err_addr),
        .ovr         (ovr),
        .upd_cnt     (upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slot(input int k);
        return param_out[8*k +: 8];
    endfunction

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req[i]            = 1'b1;
        req_addr[3*i +: 3] = a;
        req_data[8*i +: 8] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; req_addr = '0; req_data = '0; frame_start = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Returns in the first cycle after COMMIT, where commit is high.
    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic wr0(input logic [2:0] a, input logic [7:0] d);
        set_req(0, a, d);
        tick();
        chk("sat_gnt", 64'(gnt), 64'h1);
        req = '0;
        tick();
    endtask

    logic [3:0] rr_exp [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    int exp_cnt;

    initial begin
        // Reset state and an empty commit
        do_reset();
        chk("rst_param", 64'(param_out), 64'(DEF));
        chk("rst_pend",  64'(pend), 64'h0);
        chk("rst_cnt",   64'(upd_cnt), 64'h0);
        chk("rst_gnt",   64'(gnt), 64'h0);
        chk("rst_ovr",   64'(ovr), 64'h0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("empty_commit_early", 64'(commit), 64'h0);
        tick();
        chk("empty_commit", 64'(commit), 64'h1);
        chk("empty_param", 64'(param_out), 64'(DEF));
        chk("empty_cnt", 64'(upd_cnt), 64'h0);
        tick();
        chk("commit_pulse", 64'(commit), 64'h0);

        // Single write to XD
        set_req(0, 3'd2, 8'h55);
        tick();
        chk("sw_gnt", 64'(gnt), 64'h1);
        chk("sw_pend", 64'(pend), 64'b0000100);
        chk("sw_xd_hold", 64'(slot(2)), 64'd121);
        req = '0;
        tick();
        chk("sw_gnt_pulse", 64'(gnt), 64'h0);
        frame();
        chk("sw_xd", 64'(slot(2)), 64'h55);
        chk("sw_pend_clr", 64'(pend), 64'h0);
        chk("sw_cnt", 64'(upd_cnt), 64'd1);
        chk("sw_commit", 64'(commit), 64'h1);

        // Round-robin with all four held
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'(8'h10 + i));
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rr_gnt%0d", c), 64'(gnt), 64'(rr_exp[c]));
        end
        req = '0;
        tick();
        chk("rr_pend", 64'(pend), 64'b0001111);
        frame();
        chk("rr_param", 64'(param_out[31:0]), 64'h13121110);
        chk("rr_cnt", 64'(upd_cnt), 64'd4);

        // Request colliding with frame_start
        do_reset();
        set_req(1, 3'd4, 8'hAA);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("col_gnt_commit", 64'(gnt), 64'h0);
        tick();
        chk("col_gnt_after", 64'(gnt), 64'h2);
        chk("col_commit", 64'(commit), 64'h1);
        chk("col_rm_hold", 64'(slot(4)), 64'd141);
        chk("col_pend", 64'(pend), 64'b0010000);
        req = '0;
        tick();
        frame();
        chk("col_rm", 64'(slot(4)), 64'hAA);
        chk("col_cnt", 64'(upd_cnt), 64'd1);

        // Bad address and overrun
        do_reset();
        set_req(2, 3'd7, 8'h99);
        tick();
        chk("err_gnt", 64'(gnt), 64'h4);
        chk("err_addr", 64'(err_addr), 64'h1);
        chk("err_pend", 64'(pend), 64'h0);
        req = '0;
        tick();
        chk("err_pulse", 64'(err_addr), 64'h0);
        frame_start = 1'b1;
        tick();
        tick();
        frame_start = 1'b0;
        chk("ovr_set", 64'(ovr), 64'h1);
        tick(); tick(); tick();
        chk("ovr_sticky", 64'(ovr), 64'h1);
        chk("ovr_param", 64'(param_out), 64'(DEF));
        do_reset();
        chk("ovr_rst", 64'(ovr), 64'h0);

        // upd_cnt saturation
        for (int f = 0; f < 40; f++) begin
            for (int s = 0; s < 7; s++) wr0(3'(s), 8'(f + s));
            frame();
            exp_cnt = 7 * (f + 1);
            if (exp_cnt > 255) exp_cnt = 255;
            chk($sformatf("sat_cnt%0d", f), 64'(upd_cnt), 64'(exp_cnt));
        end
        chk("sat_aru", 64'(slot(6)), 64'd45);
        chk("sat_corr", 64'(slot(0)), 64'd39);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
